// File: rtl/wb_counter_regs_pkg.sv
// Shared constants, FSM state type and request payload for the Wishbone
// counter register block.
package wb_counter_regs_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned CTRL_W = 3;

  localparam logic [OFF_W-1:0] OFF_CTRL   = 6'h00;
  localparam logic [OFF_W-1:0] OFF_LOAD   = 6'h01;
  localparam logic [OFF_W-1:0] OFF_COUNT  = 6'h02;
  localparam logic [OFF_W-1:0] OFF_STATUS = 6'h03;
  localparam logic [OFF_W-1:0] OFF_CMP    = 6'h04;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_UP     = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ack_state_e;

  typedef struct packed {
    logic              we;
    logic [OFF_W-1:0]  off;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] dat;
  } wb_req_t;

  // Expand byte enables into a bit mask over the data word.
  function automatic logic [DATA_W-1:0] byte_mask(input logic [SEL_W-1:0] sel);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(SEL_W); i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_counter_regs_if.sv
// Wishbone classic slave bus bundle for the counter register block.
interface wb_counter_regs_if;
  import wb_counter_regs_pkg::*;

  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [SEL_W-1:0]  wbs_sel_i;
  logic [ADDR_W-1:0] wbs_adr_i;
  logic [DATA_W-1:0] wbs_dat_i;
  logic              wbs_ack_o;
  logic [DATA_W-1:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_ack_fsm.sv
// IDLE/ACK handshake FSM: one registered ack per accepted request and a
// combinational commit strobe on the IDLE->ACK transition.
module wb_ack_fsm
  import wb_counter_regs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic commit_c,
  output logic ack
);

  ack_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack     <= 1'b0;
    end else begin
      state_q <= state_d;
      ack     <= (state_d == ST_ACK);
    end
  end

  always_comb begin
    state_d  = state_q;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d  = ST_ACK;
          commit_c = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/wb_counter_regs.sv
// Wishbone register front-end for an external up/down counter: control,
// load, compare and a sticky compare-match interrupt.
module wb_counter_regs
  import wb_counter_regs_pkg::*;
#(
  parameter int unsigned BITS      = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_counter_regs_if.slave wb,
  output logic            cnt_en_o,
  output logic            cnt_up_o,
  output logic            cnt_load_o,
  output logic [BITS-1:0] cnt_load_val_o,
  input  logic [BITS-1:0] cnt_val_i,
  output logic            irq_o
);

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  wb_req_t           req_c;
  logic              req_valid_c;
  logic              commit_c;
  logic              wr_c;
  logic              ack;
  logic [DATA_W-1:0] wmask_c;
  logic [DATA_W-1:0] rdata_c;
  logic [CTRL_W-1:0] ctrl_q;
  logic [BITS-1:0]   load_q;
  logic [BITS-1:0]   cmp_q;
  logic              match_q;
  logic              match_set_c;
  logic              match_clr_c;
  logic              unused_adr;

  // Assert asynchronously, release two clocks after wb_rst_i rises.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    req_c.we  = wb.wbs_we_i;
    req_c.off = wb.wbs_adr_i[7:2];
    req_c.sel = wb.wbs_sel_i;
    req_c.dat = wb.wbs_dat_i;
  end

  assign req_valid_c = wb.wbs_cyc_i && wb.wbs_stb_i &&
                       (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign unused_adr  = ^wb.wbs_adr_i[1:0];

  wb_ack_fsm u_ack_fsm (
    .clk       (wb_clk_i),
    .rst_n     (rst_n),
    .req_valid (req_valid_c),
    .commit_c  (commit_c),
    .ack       (ack)
  );

  assign wb.wbs_ack_o = ack;
  assign wr_c         = commit_c && req_c.we;
  assign wmask_c      = byte_mask(req_c.sel);

  function automatic logic [BITS-1:0] apply_wr(input logic [BITS-1:0]   old,
                                               input logic [DATA_W-1:0] dat,
                                               input logic [DATA_W-1:0] mask);
    return BITS'((DATA_W'(old) & ~mask) | (dat & mask));
  endfunction

  always_comb begin
    rdata_c = '0;
    case (req_c.off)
      OFF_CTRL:   rdata_c = DATA_W'(ctrl_q);
      OFF_LOAD:   rdata_c = DATA_W'(load_q);
      OFF_COUNT:  rdata_c = DATA_W'(cnt_val_i);
      OFF_STATUS: rdata_c = DATA_W'(match_q);
      OFF_CMP:    rdata_c = DATA_W'(cmp_q);
      default:    rdata_c = '0;
    endcase
  end

  // A match condition in the same cycle as a W1C keeps MATCH set.
  assign match_set_c = ctrl_q[CTRL_EN] && (cnt_val_i == cmp_q);
  assign match_clr_c = wr_c && (req_c.off == OFF_STATUS) &&
                       req_c.sel[0] && req_c.dat[0];

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      load_q       <= '0;
      cmp_q        <= {BITS{1'b1}};
      match_q      <= 1'b0;
      irq_o        <= 1'b0;
      cnt_load_o   <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_dat_o <= (commit_c && !req_c.we) ? rdata_c : '0;
      cnt_load_o   <= wr_c && (req_c.off == OFF_LOAD) && (|req_c.sel);
      if (wr_c && (req_c.off == OFF_CTRL) && req_c.sel[0])
        ctrl_q <= req_c.dat[CTRL_W-1:0];
      if (wr_c && (req_c.off == OFF_LOAD))
        load_q <= apply_wr(load_q, req_c.dat, wmask_c);
      if (wr_c && (req_c.off == OFF_CMP))
        cmp_q <= apply_wr(cmp_q, req_c.dat, wmask_c);
      if (match_set_c)      match_q <= 1'b1;
      else if (match_clr_c) match_q <= 1'b0;
      irq_o <= match_q && ctrl_q[CTRL_IRQ_EN];
    end
  end

  assign cnt_en_o       = ctrl_q[CTRL_EN];
  assign cnt_up_o       = ctrl_q[CTRL_UP];
  assign cnt_load_val_o = load_q;

endmodule

// File: doc/wb_counter_regs.md
WB_COUNTER_REGS -- requirements
Module: wb_counter_regs

Interface
REQ-001 Parameter BITS, default 16, SHALL set the counter data width (1..32).
REQ-002 Parameter BASE_ADDR, default 32'h3000_0000, SHALL set the block base; bits [31:8] select the block.
REQ-003 Ports SHALL be:
- wb_clk_i  in  1  sole clock; all state on its rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- cnt_en_o  out  1  counter run enable.
- cnt_up_o  out  1  count direction: 1 up, 0 down.
- cnt_load_o  out  1  one-cycle load strobe to the counter.
- cnt_load_val_o  out  BITS  value to load.
- cnt_val_i  in  BITS  live count from the counter stage.
- irq_o  out  1  compare-match interrupt.

Function
REQ-004 A request SHALL be valid when cyc & stb are high and wbs_adr_i[31:8] == BASE_ADDR[31:8]; register offset is wbs_adr_i[7:2].
REQ-005 The ack FSM SHALL have states IDLE and ACK: IDLE->ACK on a valid request; ACK->IDLE unconditionally.
REQ-006 wbs_ack_o SHALL be high exactly during ACK: one cycle, latency 1 cycle after the request is sampled; never two back-to-back acks.
REQ-007 The register map SHALL be: 0x00 CTRL (bit0 EN, bit1 UP, bit2 IRQ_EN), 0x04 LOAD (BITS, R/W), 0x08 COUNT (RO, cnt_val_i), 0x0C STATUS (bit0 MATCH, write-1-to-clear), 0x10 CMP (BITS, R/W).
REQ-008 Writes SHALL commit on the IDLE->ACK edge, gated per byte by wbs_sel_i; bits at or above BITS are ignored.
REQ-009 wbs_dat_o SHALL be registered with the ack, zero-extended above BITS, and zero when not acking.
REQ-010 Unmapped offsets SHALL be acked; reads return 0; writes have no effect.
REQ-011 A write to LOAD with any sel bit set SHALL pulse cnt_load_o high for exactly the ACK cycle, with cnt_load_val_o already holding the new value.
REQ-012 cnt_en_o and cnt_up_o SHALL equal CTRL.EN and CTRL.UP directly.
REQ-013 MATCH SHALL set in the cycle after cnt_val_i == CMP is sampled while EN=1, and stay set until cleared.
REQ-014 If a set condition and a W1C write of MATCH occur in the same cycle, set SHALL win.
REQ-015 irq_o SHALL be a register equal to MATCH & IRQ_EN.
REQ-016 Requests that drop cyc/stb before ack SHALL still complete the ACK cycle; writes already committed are kept.

Reset
REQ-017 Asserting wb_rst_i low SHALL immediately force: FSM IDLE, wbs_ack_o=0, wbs_dat_o=0, CTRL=0, LOAD=0, CMP={BITS{1'b1}}, MATCH=0, cnt_load_o=0, irq_o=0.
REQ-018 Reset asserted mid-transaction SHALL abort the ack; the master must retry.
REQ-019 Release SHALL be synchronised to wb_clk_i by a two-flop deassertion synchroniser. Assertion remains asynchronous.

Structure
REQ-020 A shared package SHALL hold the offset constants (CTRL/LOAD/COUNT/STATUS/CMP), CTRL bit indices and the FSM state enum.
REQ-021 One sub-module, wb_ack_fsm, SHALL hold the IDLE/ACK FSM and emit the commit strobe; register storage stays in the top.

Verification
REQ-022 Write CTRL=0x3 with sel=4'hF -> ack 1 cycle later for 1 cycle; cnt_en_o=1, cnt_up_o=1; read CTRL returns 0x3.
REQ-023 Write LOAD=0x1234, sel=4'b0001 -> LOAD=0x0034; cnt_load_o high 1 cycle with cnt_load_val_o=0x0034.
REQ-024 CMP=0x0010, EN=1, IRQ_EN=1, drive cnt_val_i 0x000F then 0x0010 -> MATCH=1 next cycle, irq_o=1 the cycle after; W1C STATUS=0x1 -> irq_o=0.
REQ-025 W1C of STATUS in the same cycle that cnt_val_i==CMP -> MATCH stays 1.
REQ-026 Read offset 0x20 and address 0x3000_1000 -> first acked with 0, second never acked; no register changes.
REQ-027 Assert wb_rst_i low during ACK -> ack drops at once; all outputs at reset values; CMP reads 0xFFFF after release.
